vdc_fetch_addr: RTL

Per-column video memory address generator for the C128 VDC, sitting directly downstream of the VDC timing/signals stage. It consumes the frame, row, line and column strobes and produces, one cycle after each column start, the screen (character/bitmap) address and the attribute address to fetch from VDC RAM. It also flags the column matching the cursor address. It tracks row base addresses across the frame using the display start, attribute start and address-increment registers.

---
 rtl/vdc_fetch_addr.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vdc_fetch_addr.sv
// VDC per-column fetch address generator: tracks row/line base addresses and
// emits one registered screen/attribute address per displayed column.
module vdc_fetch_addr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fetchFrame,
  input  logic        fetchRow,
  input  logic        fetchLine,
  input  logic        newCol,
  input  logic [7:0]  reg_hd,
  input  logic [7:0]  reg_ai,
  input  logic [15:0] reg_ds,
  input  logic [15:0] reg_aa,
  input  logic [15:0] reg_cp,
  input  logic        reg_atr,
  input  logic        reg_ram64,
  output logic [15:0] dispAddr,
  output logic [15:0] attrAddr,
  output logic        dispValid,
  output logic        attrValid,
  output logic        cursorHit,
  output logic        lastCol
);

  logic [15:0] row_disp_reg, row_disp_next;
  logic [15:0] row_attr_reg, row_attr_next;
  logic [15:0] cur_disp_reg, cur_disp_next;
  logic [15:0] cur_attr_reg, cur_attr_next;
  logic [7:0]  col_left_reg, col_left_next;
  logic        active_reg, active_next;
  logic        first_row_reg, first_row_next;

  logic [15:0] disp_addr_next, attr_addr_next;
  logic        disp_valid_next, attr_valid_next, cursor_hit_next, last_col_next;

  logic [15:0] addr_mask;
  logic [15:0] row_step;
  logic        col_fire;

  assign addr_mask = reg_ram64 ? 16'hFFFF : 16'h3FFF;
  assign row_step  = {8'h00, reg_hd} + {8'h00, reg_ai};
  assign col_fire  = newCol && active_reg;

  // Row base tracking; the first fetchRow after a frame load is the row the
  // frame load already addressed, so it must not advance the base.
  always_comb begin
    row_disp_next  = row_disp_reg;
    row_attr_next  = row_attr_reg;
    first_row_next = first_row_reg;
    if (fetchFrame) begin
      row_disp_next  = reg_ds & addr_mask;
      row_attr_next  = reg_aa & addr_mask;
      first_row_next = !fetchRow;
    end else if (fetchRow) begin
      if (first_row_reg) begin
        first_row_next = 1'b0;
      end else begin
        row_disp_next = (row_disp_reg + row_step) & addr_mask;
        row_attr_next = (row_attr_reg + row_step) & addr_mask;
      end
    end
  end

  // Column walker; a fetchLine restarts the line from the (bypassed) new row base.
  always_comb begin
    cur_disp_next = cur_disp_reg;
    cur_attr_next = cur_attr_reg;
    col_left_next = col_left_reg;
    active_next   = active_reg;
    if (col_fire) begin
      cur_disp_next = (cur_disp_reg + 16'd1) & addr_mask;
      cur_attr_next = (cur_attr_reg + 16'd1) & addr_mask;
      col_left_next = col_left_reg - 8'd1;
      active_next   = (col_left_reg != 8'd1);
    end
    if (fetchLine) begin
      cur_disp_next = row_disp_next;
      cur_attr_next = row_attr_next;
      col_left_next = reg_hd;
      active_next   = (reg_hd != 8'd0);
    end
  end

  always_comb begin
    disp_valid_next = col_fire;
    attr_valid_next = col_fire && reg_atr;
    cursor_hit_next = col_fire && (cur_disp_reg == (reg_cp & addr_mask));
    last_col_next   = col_fire && (col_left_reg == 8'd1);
    disp_addr_next  = col_fire ? cur_disp_reg : dispAddr;
    attr_addr_next  = col_fire ? cur_attr_reg : attrAddr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_disp_reg  <= 16'h0000;
      row_attr_reg  <= 16'h0000;
      cur_disp_reg  <= 16'h0000;
      cur_attr_reg  <= 16'h0000;
      col_left_reg  <= 8'h00;
      active_reg    <= 1'b0;
      first_row_reg <= 1'b1;
      dispAddr      <= 16'h0000;
      attrAddr      <= 16'h0000;
      dispValid     <= 1'b0;
      attrValid     <= 1'b0;
      cursorHit     <= 1'b0;
      lastCol       <= 1'b0;
    end else if (enable) begin
      row_disp_reg  <= row_disp_next;
      row_attr_reg  <= row_attr_next;
      cur_disp_reg  <= cur_disp_next;
      cur_attr_reg  <= cur_attr_next;
      col_left_reg  <= col_left_next;
      active_reg    <= active_next;
      first_row_reg <= first_row_next;
      dispAddr      <= disp_addr_next;
      attrAddr      <= attr_addr_next;
      dispValid     <= disp_valid_next;
      attrValid     <= attr_valid_next;
      cursorHit     <= cursor_hit_next;
      lastCol       <= last_col_next;
    end
  end

endmodule
